// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction-fetch / MEM-stage memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DataWidth = 64;

  typedef enum logic [1:0] {
    StIdle,
    StIfAcc,
    StMemAcc
  } arbState_e;

  localparam logic [1:0] SizeByte   = 2'b00;
  localparam logic [1:0] SizeHalf   = 2'b01;
  localparam logic [1:0] SizeWord   = 2'b10;
  localparam logic [1:0] SizeDouble = 2'b11;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Per-access wait watchdog: counts stalled cycles, flags expiry and keeps a sticky error.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic p_Clk,
  input  logic p_Reset_n,
  input  logic p_Clear,
  input  logic p_Count,
  output logic p_Expire,
  output logic p_Error
);

  // Expiry fires on the TIMEOUT-th counted cycle, so the access never sees one more.
  localparam logic [TO_W-1:0] LastCnt = TO_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

  logic [TO_W-1:0] cntQ;
  logic            errorQ;

  assign p_Expire = (TIMEOUT != 0) && p_Count && (cntQ == LastCnt);
  assign p_Error  = errorQ;

  always_ff @(posedge p_Clk or negedge p_Reset_n) begin
    if (!p_Reset_n) begin
      cntQ   <= '0;
      errorQ <= 1'b0;
    end else begin
      if (p_Clear) begin
        cntQ <= '0;
      end else if (p_Count) begin
        cntQ <= cntQ + TO_W'(1);
      end
      if (p_Expire) begin
        errorQ <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IF (read-only) and MEM (load/store), with fairness and a watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = DataWidth,
  parameter int unsigned FAIR_LIMIT = 4,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned TO_W       = 8
) (
  input  logic             p_Clk,
  input  logic             p_Reset_n,
  input  logic             p_IF_Req,
  input  logic [WIDTH-1:0] p_IF_Addr,
  output logic             p_IF_Stall,
  output logic             p_IF_Done,
  output logic [WIDTH-1:0] p_IF_Data,
  input  logic             p_MEM_ReadData,
  input  logic [3:0]       p_MEM_WriteData,
  input  logic [WIDTH-1:0] p_MEM_Address,
  input  logic [WIDTH-1:0] p_MEM_WriteDataOut,
  output logic             p_MEM_Stall,
  output logic             p_MEM_Done,
  output logic [WIDTH-1:0] p_MEM_ReadDataIn,
  output logic             p_ARB_MemReq,
  output logic             p_ARB_MemWe,
  output logic [1:0]       p_ARB_MemSize,
  output logic [WIDTH-1:0] p_ARB_MemAddr,
  output logic [WIDTH-1:0] p_ARB_MemWdata,
  input  logic [WIDTH-1:0] p_ARB_MemRdata,
  input  logic             p_ARB_MemWait,
  output logic             p_ARB_Error
);

  localparam int unsigned      FairW   = $clog2(FAIR_LIMIT + 1);
  localparam logic [FairW-1:0] FairMax = FairW'(FAIR_LIMIT);

  arbState_e        stateQ, stateD;
  logic [FairW-1:0] fairCntQ, fairCntD;
  logic             weQ;
  logic [1:0]       sizeQ;
  logic [WIDTH-1:0] addrQ, wdataQ, ifDataQ, memDataQ;
  logic             ifDoneQ, memDoneQ;
  logic             memPend, anyDone, inAcc, complete, finish;
  logic             grantIf, grantMem, wdExpire, wdError;
  logic             unusedReserved;

  assign unusedReserved = p_MEM_WriteData[3];
  assign memPend  = p_MEM_ReadData | p_MEM_WriteData[0];
  assign anyDone  = ifDoneQ | memDoneQ;
  assign inAcc    = (stateQ != StIdle);
  assign complete = inAcc & ~p_ARB_MemWait;
  assign finish   = complete | wdExpire;

  always_comb begin
    stateD   = stateQ;
    fairCntD = fairCntQ;
    grantIf  = 1'b0;
    grantMem = 1'b0;
    case (stateQ)
      StIdle: begin
        // No grant in a Done cycle: the finished requester may still be holding its old request.
        if (!anyDone) begin
          if (memPend && !(p_IF_Req && fairCntQ == FairMax)) begin
            grantMem = 1'b1;
          end else if (p_IF_Req) begin
            grantIf = 1'b1;
          end
        end
        if (!p_IF_Req || grantIf) begin
          fairCntD = '0;
        end else if (grantMem && fairCntQ != FairMax) begin
          fairCntD = fairCntQ + FairW'(1);
        end
        if (grantMem) begin
          stateD = StMemAcc;
        end else if (grantIf) begin
          stateD = StIfAcc;
        end
      end
      StIfAcc, StMemAcc: begin
        if (finish) begin
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge p_Clk or negedge p_Reset_n) begin
    if (!p_Reset_n) begin
      stateQ   <= StIdle;
      fairCntQ <= '0;
      weQ      <= 1'b0;
      sizeQ    <= SizeByte;
      addrQ    <= '0;
      wdataQ   <= '0;
      ifDataQ  <= '0;
      memDataQ <= '0;
      ifDoneQ  <= 1'b0;
      memDoneQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      fairCntQ <= fairCntD;
      ifDoneQ  <= (stateQ == StIfAcc) && finish;
      memDoneQ <= (stateQ == StMemAcc) && finish;
      if (grantMem) begin
        weQ    <= p_MEM_WriteData[0];
        sizeQ  <= p_MEM_WriteData[2:1];
        addrQ  <= p_MEM_Address;
        wdataQ <= p_MEM_WriteDataOut;
      end else if (grantIf) begin
        weQ    <= 1'b0;
        sizeQ  <= SizeByte;
        addrQ  <= p_IF_Addr;
        wdataQ <= '0;
      end
      if (stateQ == StIfAcc && finish) begin
        ifDataQ <= wdExpire ? '0 : p_ARB_MemRdata;
      end
      // Stores leave the load data register untouched.
      if (stateQ == StMemAcc && finish && !weQ) begin
        memDataQ <= wdExpire ? '0 : p_ARB_MemRdata;
      end
    end
  end

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) u_watchdog (
    .p_Clk    (p_Clk),
    .p_Reset_n(p_Reset_n),
    .p_Clear  (grantIf | grantMem),
    .p_Count  (inAcc & p_ARB_MemWait),
    .p_Expire (wdExpire),
    .p_Error  (wdError)
  );

  assign p_ARB_MemReq     = inAcc;
  assign p_ARB_MemWe      = weQ;
  assign p_ARB_MemSize    = sizeQ;
  assign p_ARB_MemAddr    = addrQ;
  assign p_ARB_MemWdata   = wdataQ;
  assign p_ARB_Error      = wdError;
  assign p_IF_Done        = ifDoneQ;
  assign p_IF_Data        = ifDataQ;
  assign p_MEM_Done       = memDoneQ;
  assign p_MEM_ReadDataIn = memDataQ;
  // Stalls are forced low while reset is held so every output reads 0 in reset.
  assign p_IF_Stall       = p_Reset_n & p_IF_Req & ~ifDoneQ;
  assign p_MEM_Stall      = p_Reset_n & memPend & ~memDoneQ;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a small wait-programmable memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        ifReq = 1'b0;
  logic [63:0] ifAddr = '0;
  logic        ifStall, ifDone;
  logic [63:0] ifData;
  logic        memRd = 1'b0;
  logic [3:0]  memWr = '0;
  logic [63:0] memAddr = '0;
  logic [63:0] memWdataIn = '0;
  logic        memStall, memDone;
  logic [63:0] memRdataOut;
  logic        arbReq, arbWe;
  logic [1:0]  arbSize;
  logic [63:0] arbAddr, arbWdata, arbRdata;
  logic        arbWait, arbError;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [63:0] ifExpQ[$];
  logic [63:0] memExpQ[$];
  byte         orderQ[$];
  logic [63:0] lastLoad = '0;

  int unsigned waitCfg = 0;
  int unsigned waitCnt = 0;
  bit          stuck = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [63:0] mkData(input logic [63:0] a);
    return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
  endfunction

  // Memory model: MemWait held for waitCfg cycles of each access, or forever when stuck.
  assign arbRdata = mkData(arbAddr);
  assign arbWait  = stuck | (arbReq && waitCnt != 0);

  always @(posedge clk) begin
    if (!arbReq) waitCnt <= waitCfg;
    else if (waitCnt != 0) waitCnt <= waitCnt - 1;
  end

  mem_port_arbiter dut (
    .p_Clk             (clk),
    .p_Reset_n         (rstN),
    .p_IF_Req          (ifReq),
    .p_IF_Addr         (ifAddr),
    .p_IF_Stall        (ifStall),
    .p_IF_Done         (ifDone),
    .p_IF_Data         (ifData),
    .p_MEM_ReadData    (memRd),
    .p_MEM_WriteData   (memWr),
    .p_MEM_Address     (memAddr),
    .p_MEM_WriteDataOut(memWdataIn),
    .p_MEM_Stall       (memStall),
    .p_MEM_Done        (memDone),
    .p_MEM_ReadDataIn  (memRdataOut),
    .p_ARB_MemReq      (arbReq),
    .p_ARB_MemWe       (arbWe),
    .p_ARB_MemSize     (arbSize),
    .p_ARB_MemAddr     (arbAddr),
    .p_ARB_MemWdata    (arbWdata),
    .p_ARB_MemRdata    (arbRdata),
    .p_ARB_MemWait     (arbWait),
    .p_ARB_Error       (arbError)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (ifDone || memDone) begin
      if (orderQ.size() == 0) checkVal("order_unexpected", 64'(orderQ.size()), 1);
      else checkVal("grant_order", ifDone ? 64'("I") : 64'("M"), 64'(orderQ.pop_front()));
    end
    if (ifDone) begin
      if (ifExpQ.size() == 0) checkVal("if_unexpected", 64'(ifExpQ.size()), 1);
      else checkVal("if_data", ifData, ifExpQ.pop_front());
    end
    if (memDone) begin
      if (memExpQ.size() == 0) checkVal("mem_unexpected", 64'(memExpQ.size()), 1);
      else checkVal("mem_data", memRdataOut, memExpQ.pop_front());
    end
  end

  task automatic ifFetch(input logic [63:0] addr, input logic [63:0] expData,
                         input int unsigned limit, output int unsigned reqCycles);
    bit seen;
    seen = 1'b0;
    reqCycles = 0;
    ifExpQ.push_back(expData);
    orderQ.push_back("I");
    ifAddr = addr;
    ifReq  = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ifDone) begin
        seen = 1'b1;
        break;
      end
      if (arbReq) reqCycles++;
    end
    checkVal("if_done_seen", 64'(seen), 1);
    ifReq = 1'b0;
  endtask

  task automatic memAccess(input bit rd, input bit st, input logic [1:0] size,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           output int unsigned reqCycles);
    bit seen;
    bit expWe;
    seen  = 1'b0;
    expWe = st;
    reqCycles = 0;
    if (!st) lastLoad = mkData(addr);
    memExpQ.push_back(lastLoad);
    orderQ.push_back("M");
    memRd      = rd;
    memWr      = {1'b0, size, st};
    memAddr    = addr;
    memWdataIn = wdata;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (memDone) begin
        seen = 1'b1;
        break;
      end
      if (arbReq) begin
        reqCycles++;
        checkVal("mem_we", 64'(arbWe), 64'(expWe));
        checkVal("mem_addr", arbAddr, addr);
        checkVal("mem_size", 64'(arbSize), 64'(size));
        if (expWe) checkVal("mem_wdata", arbWdata, wdata);
        checkVal("mem_stall_busy", 64'(memStall), 1);
      end
    end
    checkVal("mem_done_seen", 64'(seen), 1);
    checkVal("mem_stall_done", 64'(memStall), 0);
    memRd = 1'b0;
    memWr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int unsigned n;
    int unsigned ifSeen;

    // Reset state
    cyc(2);
    checkVal("rst_memreq", 64'(arbReq), 0);
    checkVal("rst_if_done", 64'(ifDone), 0);
    checkVal("rst_mem_done", 64'(memDone), 0);
    checkVal("rst_error", 64'(arbError), 0);
    checkVal("rst_addr", arbAddr, 0);
    checkVal("rst_if_data", ifData, 0);
    rstN = 1'b1;
    cyc(2);

    // Lone IF fetch, no wait: MemReq one cycle after the request, Done the cycle after.
    ifExpQ.push_back(mkData(64'h1000));
    orderQ.push_back("I");
    ifAddr = 64'h1000;
    ifReq  = 1'b1;
    @(negedge clk);
    checkVal("if1_memreq", 64'(arbReq), 1);
    checkVal("if1_addr", arbAddr, 64'h1000);
    checkVal("if1_we", 64'(arbWe), 0);
    checkVal("if1_size", 64'(arbSize), 0);
    checkVal("if1_stall", 64'(ifStall), 1);
    checkVal("if1_done_early", 64'(ifDone), 0);
    @(negedge clk);
    checkVal("if1_done", 64'(ifDone), 1);
    checkVal("if1_memreq_off", 64'(arbReq), 0);
    checkVal("if1_stall_off", 64'(ifStall), 0);
    ifReq = 1'b0;
    cyc(2);

    // Store with three wait cycles: MemReq held four cycles, fields stable.
    waitCfg = 3;
    cyc(1);
    memAccess(1'b0, 1'b1, 2'b11, 64'h2008, 64'hDEAD_BEEF, n);
    checkVal("st_req_cycles", 64'(n), 4);
    waitCfg = 0;
    cyc(2);

    // Load then store to the same address; store must not touch the load register.
    memAccess(1'b1, 1'b0, 2'b11, 64'h2008, 64'h0, n);
    checkVal("ld_req_cycles", 64'(n), 1);
    cyc(1);
    memAccess(1'b0, 1'b1, 2'b10, 64'h2008, 64'h1234_5678_9ABC_DEF0, n);
    cyc(1);
    // Load and store flags together behave as a store.
    memAccess(1'b1, 1'b1, 2'b01, 64'h2010, 64'h55AA, n);
    cyc(2);

    // Both requesters held: MEM wins until the fairness limit forces IF through.
    for (int r = 0; r < 2; r++) begin
      for (int m = 0; m < 4; m++) begin
        orderQ.push_back("M");
        memExpQ.push_back(mkData(64'h3000));
      end
      orderQ.push_back("I");
      ifExpQ.push_back(mkData(64'h1100));
    end
    lastLoad = mkData(64'h3000);
    ifAddr  = 64'h1100;
    memAddr = 64'h3000;
    memWr   = 4'b0110;
    memRd   = 1'b1;
    ifReq   = 1'b1;
    ifSeen  = 0;
    for (int i = 0; i < 100 && ifSeen < 2; i++) begin
      @(negedge clk);
      if (ifDone) ifSeen++;
    end
    checkVal("fair_if_served", 64'(ifSeen), 2);
    ifReq = 1'b0;
    memRd = 1'b0;
    memWr = '0;
    cyc(3);
    checkVal("fair_order_drained", 64'(orderQ.size()), 0);

    // Watchdog: MemWait stuck high.
    stuck = 1'b1;
    ifFetch(64'h4000, 64'h0, 400, n);
    checkVal("wd_req_cycles", 64'(n), 255);
    checkVal("wd_error", 64'(arbError), 1);
    stuck = 1'b0;
    cyc(3);
    checkVal("wd_error_sticky", 64'(arbError), 1);
    ifFetch(64'h4008, mkData(64'h4008), 10, n);
    checkVal("wd_error_sticky2", 64'(arbError), 1);
    cyc(2);

    // Reset in the middle of a MEM access.
    waitCfg = 10;
    cyc(1);
    memAddr = 64'h5000;
    memWr   = 4'b0110;
    memRd   = 1'b1;
    for (int i = 0; i < 5 && !arbReq; i++) @(negedge clk);
    checkVal("rst_mid_started", 64'(arbReq), 1);
    cyc(2);
    #2 rstN = 1'b0;
    #1;
    checkVal("rst_mid_memreq", 64'(arbReq), 0);
    checkVal("rst_mid_done", 64'(memDone), 0);
    checkVal("rst_mid_stall", 64'(memStall), 0);
    checkVal("rst_mid_error", 64'(arbError), 0);
    @(negedge clk);
    memRd = 1'b0;
    memWr = '0;
    waitCfg = 0;
    cyc(2);
    rstN = 1'b1;
    cyc(2);
    ifFetch(64'h6000, mkData(64'h6000), 10, n);
    cyc(3);

    checkVal("if_q_empty", 64'(ifExpQ.size()), 0);
    checkVal("mem_q_empty", 64'(memExpQ.size()), 0);
    checkVal("order_q_empty", 64'(orderQ.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
